pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 16-bit MIPS pipeline (IF/ID and later stages).

---
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a one-entry skid buffer.
// All state changes on the falling edge of clk; flush turns held entries into bubbles.
module pipe_stage_reg #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 16,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc_plus_2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus_2,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a falling edge where valid and ready are both 1.
  // Upstream: in_valid & in_ready; downstream: out_valid & out_ready. in_ready and
  // out_valid come straight from registered state, never from out_ready.

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc_plus_2;
  logic               in_fire;
  logic               out_fire;

  assign out_valid = state[1];
  assign in_ready  = ~state[0];
  assign dbg_state = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(negedge clk) begin
    if (rst || flush) begin
      state          <= EMPTY;
      out_instr      <= NOP_WORD;
      out_pc_plus_2  <= '0;
      skid_instr     <= '0;
      skid_pc_plus_2 <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state         <= FULL;
            out_instr     <= in_instr;
            out_pc_plus_2 <= in_pc_plus_2;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            out_instr     <= in_instr;
            out_pc_plus_2 <= in_pc_plus_2;
          end else if (in_fire) begin
            // Downstream stalled: park the new word behind the held one.
            state          <= SKID;
            skid_instr     <= in_instr;
            skid_pc_plus_2 <= in_pc_plus_2;
          end else if (out_fire) begin
            state         <= EMPTY;
            out_instr     <= NOP_WORD;
            out_pc_plus_2 <= '0;
          end
        end
        SKID: begin
          if (out_fire) begin
            state         <= FULL;
            out_instr     <= skid_instr;
            out_pc_plus_2 <= skid_pc_plus_2;
          end
        end
        default: begin
          state          <= EMPTY;
          out_instr      <= NOP_WORD;
          out_pc_plus_2  <= '0;
          skid_instr     <= '0;
          skid_pc_plus_2 <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a capacity-2 FIFO reference queue predicts every output
// after each falling edge; scenario tasks add their own targeted checks.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc_plus_2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc_plus_2;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  bit          seen_cccc = 0;

  pipe_stage_reg #(.INSTR_W(16), .PC_W(16), .NOP_WORD(16'h0)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_pc_plus_2(in_pc_plus_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc_plus_2(out_pc_plus_2),
    .dbg_state(dbg_state)
  );

  // Clock starts high so the first active (falling) edge is at t=5.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Drives one edge's inputs, advances the reference queue, then checks all outputs.
  task automatic drive_cycle(input logic iv, input logic [15:0] ii, input logic [15:0] ip,
                             input logic ordy, input logic fl, input logic rs);
    logic        m_in;
    logic        m_out;
    logic        exp_v;
    logic        exp_r;
    logic [15:0] exp_i;
    logic [15:0] exp_p;
    logic [1:0]  exp_s;
    in_valid     = iv;
    in_instr     = ii;
    in_pc_plus_2 = ip;
    out_ready    = ordy;
    flush        = fl;
    rst          = rs;
    m_in  = iv && (exp_q.size() < 2);
    m_out = ordy && (exp_q.size() > 0);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (m_out) void'(exp_q.pop_front());
      if (m_in) exp_q.push_back({ii, ip});
    end
    @(negedge clk);
    #2;
    exp_v = exp_q.size() > 0;
    exp_r = exp_q.size() < 2;
    exp_i = exp_v ? exp_q[0][31:16] : 16'h0;
    exp_p = exp_v ? exp_q[0][15:0] : 16'h0;
    exp_s = {exp_v, exp_q.size() == 2};
    if (out_valid && out_instr === 16'hCCCC) seen_cccc = 1'b1;
    compared++;
    if (out_valid !== exp_v) begin
      mismatched++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, exp_v, $time);
    end
    compared++;
    if (in_ready !== exp_r) begin
      mismatched++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_r, $time);
    end
    compared++;
    if (out_instr !== exp_i) begin
      mismatched++;
      $display("FAIL out_instr: got %h expected %h at %0t", out_instr, exp_i, $time);
    end
    compared++;
    if (out_pc_plus_2 !== exp_p) begin
      mismatched++;
      $display("FAIL out_pc_plus_2: got %h expected %h at %0t", out_pc_plus_2, exp_p, $time);
    end
    compared++;
    if (dbg_state !== exp_s) begin
      mismatched++;
      $display("FAIL dbg_state: got %b expected %b at %0t", dbg_state, exp_s, $time);
    end
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    compared++;
    if ({out_valid, in_ready, out_instr, out_pc_plus_2} !== {1'b0, 1'b1, 16'h0, 16'h0}) begin
      mismatched++;
      $display("FAIL reset_values: got v=%b r=%b i=%h p=%h expected v=0 r=1 i=0000 p=0000",
               out_valid, in_ready, out_instr, out_pc_plus_2);
    end
  endtask

  task automatic test_stream();
    logic [15:0] words[3];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, words[i], 16'(2 * (i + 1)), 1'b1, 1'b0, 1'b0);
      compared++;
      if (out_valid !== 1'b1 || out_instr !== words[i]) begin
        mismatched++;
        $display("FAIL stream_%0d: got v=%b i=%h expected v=1 i=%h", i, out_valid, out_instr, words[i]);
      end
    end
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_skid();
    drive_cycle(1'b1, 16'hAAAA, 16'h0010, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'hBBBB, 16'h0012, 1'b0, 1'b0, 1'b0);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL skid_full_ready: got %b expected 0", in_ready);
    end
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (in_ready !== 1'b1 || out_instr !== 16'hBBBB) begin
      mismatched++;
      $display("FAIL skid_release: got r=%b i=%h expected r=1 i=bbbb", in_ready, out_instr);
    end
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 16'h4444, 16'h0020, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h5555, 16'h0022, 1'b0, 1'b0, 1'b0);
    seen_cccc = 1'b0;
    drive_cycle(1'b1, 16'hCCCC, 16'h0024, 1'b1, 1'b1, 1'b0);
    compared++;
    if ({out_valid, in_ready, out_instr} !== {1'b0, 1'b1, 16'h0}) begin
      mismatched++;
      $display("FAIL flush_values: got v=%b r=%b i=%h expected v=0 r=1 i=0000",
               out_valid, in_ready, out_instr);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (seen_cccc !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_dropped: got seen=%b expected 0", seen_cccc);
    end
  endtask

  task automatic test_rst_flush();
    drive_cycle(1'b1, 16'h6666, 16'h0030, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h7777, 16'h0032, 1'b0, 1'b1, 1'b1);
    compared++;
    if ({out_valid, in_ready, out_instr, out_pc_plus_2} !== {1'b0, 1'b1, 16'h0, 16'h0}) begin
      mismatched++;
      $display("FAIL rst_flush_values: got v=%b r=%b i=%h p=%h expected v=0 r=1 i=0000 p=0000",
               out_valid, in_ready, out_instr, out_pc_plus_2);
    end
    drive_cycle(1'b1, 16'h8888, 16'h0034, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h9999, 16'h0036, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'h5A5A, 16'h0038, 1'b1, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b1 || out_instr !== 16'h5A5A || out_pc_plus_2 !== 16'h0038) begin
      mismatched++;
      $display("FAIL post_reset_latency: got v=%b i=%h p=%h expected v=1 i=5a5a p=0038",
               out_valid, out_instr, out_pc_plus_2);
    end
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL random_drain: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc_plus_2 = '0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_rst_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
